// File: rtl/dti_stream_pkg.sv
// Shared conventions and arithmetic helpers for dti stream reducers.
// A dti word carries its end-of-transaction flag in the MSB.
package dti_stream_pkg;

  function automatic int eot_pos(input int word_w);
    return word_w - 1;
  endfunction

  // Adds two w-bit operands (1 <= w <= 64) held zero-padded in 64 bits.
  // The result is either wrapped or clamped, and its bits above w are zero.
  function automatic logic [63:0] add_sat(input logic [63:0] a,
                                          input logic [63:0] b,
                                          input int          w,
                                          input bit          is_signed,
                                          input bit          sat);
    logic [64:0] full;
    logic [63:0] mask, sum, sa, sb, ss, carry, res;
    mask  = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    full  = {1'b0, a} + {1'b0, b};
    sum   = full[63:0] & mask;
    sa    = a >> (w - 1);
    sb    = b >> (w - 1);
    ss    = sum >> (w - 1);
    carry = 64'(full >> w);
    res   = sum;
    if (sat) begin
      if (is_signed) begin
        if (sa[0] == sb[0] && ss[0] != sa[0])
          res = sa[0] ? (64'd1 << (w - 1)) : (mask >> 1);
      end else if (carry[0]) begin
        res = mask;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/dti_if.sv
// dti valid/ready stream: the producer drives valid and data, the consumer drives ready.
interface dti #(parameter int W = 8) ();
  logic         valid;
  logic         ready;
  logic [W-1:0] data;

  modport producer (output valid, output data, input ready);
  modport consumer (input valid, input data, output ready);
endinterface

// File: rtl/qaccum_res_reg.sv
// One-entry result slot: load wins over drain, so load+drain in one cycle keeps it full.
module qaccum_res_reg #(
  parameter int W = 48
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         drain,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic         full
);

  // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
  // NOTE: q is reset as well, since the output data must read zero out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      full <= 1'b0;
      q    <= '0;
    end else if (load) begin
      full <= 1'b1;
      q    <= d;
    end else if (drain) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/qaccum.sv
// Stream reducer: sums each eot-terminated burst of din into one {cnt, sum} result on dout.
module qaccum
  import dti_stream_pkg::*;
#(
  parameter int W_DATA   = 16,
  parameter int W_SUM    = 32,
  parameter int W_CNT    = 16,
  parameter int SIGNED   = 0,
  parameter int SATURATE = 0
) (
  input logic    clk,
  input logic    rst,
  dti.consumer   din,
  dti.producer   dout
);

  typedef struct packed {
    logic              eot;
    logic [W_DATA-1:0] data;
  } din_t;

  typedef struct packed {
    logic [W_CNT-1:0] cnt;
    logic [W_SUM-1:0] sum;
  } dout_t;

  localparam int EOT = eot_pos($bits(din_t));

  if (W_SUM < W_DATA) begin : g_chk_sum
    $error("qaccum: W_SUM must be >= W_DATA");
  end
  if (W_SUM > 64) begin : g_chk_sum_max
    $error("qaccum: W_SUM above 64 is not supported by add_sat");
  end
  if ($size(din.data) != W_DATA + 1 || EOT != W_DATA) begin : g_chk_din
    $error("qaccum: din.data must be W_DATA+1 bits with eot in the MSB");
  end
  if ($size(dout.data) != W_CNT + W_SUM) begin : g_chk_dout
    $error("qaccum: dout.data must be W_CNT+W_SUM bits");
  end

  din_t             din_w;
  dout_t            res_in;
  dout_t            res_q;
  logic [W_SUM-1:0] acc;
  logic [W_SUM-1:0] ext;
  logic [W_SUM-1:0] nsum;
  logic [W_CNT-1:0] acc_cnt;
  logic [W_CNT-1:0] cnt_inc;
  logic             hs;
  logic             last;
  logic             full;

  assign din_w = din.data;

  if (SIGNED != 0) begin : g_sext
    assign ext = W_SUM'($signed(din_w.data));
  end else begin : g_zext
    assign ext = W_SUM'(din_w.data);
  end

  assign nsum    = W_SUM'(add_sat(64'(acc), 64'(ext), W_SUM, SIGNED != 0, SATURATE != 0));
  assign cnt_inc = acc_cnt + 1'b1;

  // Only an eot element needs the result slot, so only it can be held off.
  assign din.ready = ~din_w.eot | ~full | dout.ready;
  assign hs        = din.valid & din.ready;
  assign last      = hs & din_w.eot;
  assign res_in    = '{cnt: cnt_inc, sum: nsum};

  always_ff @(posedge clk) begin
    if (rst) begin
      acc     <= '0;
      acc_cnt <= '0;
    end else if (hs) begin
      if (din_w.eot) begin
        acc     <= '0;
        acc_cnt <= '0;
      end else begin
        acc     <= nsum;
        acc_cnt <= cnt_inc;
      end
    end
  end

  qaccum_res_reg #(.W(W_CNT + W_SUM)) u_res (
    .clk   (clk),
    .rst   (rst),
    .load  (last),
    .drain (dout.ready),
    .d     (res_in),
    .q     (res_q),
    .full  (full)
  );

  assign dout.valid = full;
  assign dout.data  = res_q;

endmodule
